l2_access_arbiter: RTL and testbench
====================================

L2_ACCESS_ARBITER -- requirements
Module: l2_access_arbiter

Interface
REQ-001 SHALL have parameter FILL_LAT, default 2, meaning dmem read latency in cycles during a LOAD miss fill (legal 1..15).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  in  1  core request, held high until matching ack.
REQ-005 SHALL have ports op0/op1  in  2  request type: 2'b01 LOAD, 2'b10 FLUSH; other values are illegal and treated as FLUSH-less no-op completed with ack.
REQ-006 SHALL have ports addr0/addr1  in  32  byte address, and wdata0/wdata1  in  32  flush write data.
REQ-007 SHALL have ports ack0/ack1  out  1  one-cycle completion pulse, and rdata  out  32  load data valid with ack.
REQ-008 SHALL have ports l2_opcode  out  7, l2_flush  out  1, l2_bus_address  out  32, l2_bus_data  out  32, l2_bus_tag  out  24  toward the L2 array.
REQ-009 SHALL have ports l2_hit  in  2  (2'b10 hit, 2'b01 miss), l2_data  in  32, dmem_data  in  32.
REQ-010 SHALL have ports busy  out  1  FSM not IDLE, and grant_id  out  1  owner of the current transaction.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, FILL, WRITE, RESP.
REQ-012 IDLE: no request -> stay; any req -> latch winner's op/addr/wdata, set grant_id, go LOOKUP next cycle.
REQ-013 Arbitration SHALL be round-robin: pointer rr starts at 0; both requesting -> grant rr; single requester -> granted regardless of rr; rr <= ~grant_id on every grant.
REQ-014 LOOKUP (1 cycle): LOAD -> l2_opcode=7'b0000011; sample l2_hit: 2'b10 -> capture l2_data into rdata, go RESP; 2'b01 -> go FILL; FLUSH -> go WRITE.
REQ-015 FILL: l2_opcode held 7'b0000011 for exactly FILL_LAT cycles (down-counter, 4 bits); on last cycle capture dmem_data into rdata, go RESP; load miss latency = 1+FILL_LAT+1 cycles req-to-ack.
REQ-016 WRITE (1 cycle): l2_flush=1, l2_opcode=7'b0100011, l2_bus_data=latched wdata; go RESP.
REQ-017 RESP (1 cycle): ack of grant_id =1, other ack 0; go IDLE; new request arbitrated no earlier than following IDLE cycle.
REQ-018 l2_bus_address SHALL equal latched addr in all non-IDLE states; l2_bus_tag = {addr[31:9],1'b0}.
REQ-019 Outside LOOKUP/FILL/WRITE: l2_opcode=7'b0, l2_flush=0; all L2-side outputs registered.
REQ-020 Inputs from requesters SHALL be sampled only in IDLE; changes or req drop mid-transaction SHALL be ignored and the transaction completes with ack.
REQ-021 rdata SHALL hold last captured value until next capture; FLUSH leaves rdata unchanged.
REQ-022 l2_hit values 2'b00/2'b11 in LOOKUP SHALL be treated as miss.

Reset
REQ-023 reset low SHALL immediately force state IDLE, rr=0, grant_id=0, counter=0, ack0/ack1=0, rdata=0, l2_opcode=0, l2_flush=0, l2_bus_address/data/tag=0, busy=0.
REQ-024 Reset mid-transaction SHALL abort without ack; first post-reset arbitration uses rr=0.
REQ-025 Reset release SHALL be synchronized externally; block adds no synchronizer.

Structure
REQ-026 Opcode constants (LOAD 7'b0000011, STORE 7'b0100011), hit codes, op codes and FSM state enum SHALL live in shared package cache_pkg.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], rr, grant_valid, grant_id); rest flat.

Verification
REQ-028 req0 LOAD addr 0x0000_1204, l2_hit=10, l2_data=0xDEAD_BEEF -> ack0 at cycle 3, rdata=0xDEADBEEF, l2_bus_tag=0x000012.
REQ-029 req1 LOAD miss, FILL_LAT=2, dmem_data=0x1234_5678 -> l2_opcode=0x03 for 3 cycles, ack1 at cycle 5, rdata=0x12345678.
REQ-030 req0 and req1 simultaneous after reset -> core0 acked first, core1 second; repeat -> core0 first again (rr alternates).
REQ-031 req0 FLUSH addr 0x0000_0400 wdata 0xA5A5_A5A5 -> one cycle l2_flush=1, l2_opcode=0x23, l2_bus_data=0xA5A5A5A5, ack0 next cycle, rdata unchanged.
REQ-032 reset asserted during FILL -> outputs zero same cycle, no ack; after release req1 LOAD serviced normally.
REQ-033 req0 dropped during FILL with addr changed -> l2_bus_address unchanged, ack0 still pulses once.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants for the L2 access arbiter: L2 opcodes, hit code, request ops and FSM states.
package cache_pkg;
  localparam logic [6:0] L2_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] L2_OPC_STORE = 7'b0100011;

  // Only this code counts as a hit; 2'b01 and the undefined codes are all misses.
  localparam logic [1:0] L2_HIT_CODE  = 2'b10;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b01,
    OP_FLUSH = 2'b10
  } req_op_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/l2_access_arbiter_if.sv
// Bundle of the two core request ports and the L2 / dmem side of the arbiter.
interface l2_access_arbiter_if;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic [6:0]  l2_opcode;
  logic        l2_flush;
  logic [31:0] l2_bus_address, l2_bus_data;
  logic [23:0] l2_bus_tag;
  logic [1:0]  l2_hit;
  logic [31:0] l2_data, dmem_data;
  logic        busy, grant_id;

  modport master (
    output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, l2_hit, l2_data, dmem_data,
    input  ack0, ack1, rdata, l2_opcode, l2_flush, l2_bus_address, l2_bus_data, l2_bus_tag,
           busy, grant_id
  );

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, l2_hit, l2_data, dmem_data,
    output ack0, ack1, rdata, l2_opcode, l2_flush, l2_bus_address, l2_bus_data, l2_bus_tag,
           busy, grant_id
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: rr breaks the tie only when both cores request.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       grant_valid,
  output logic       grant_id
);
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    if (req == 2'b11) grant_id = rr;
    else if (req[1])  grant_id = 1'b1;
  end
endmodule

// File: rtl/l2_access_arbiter.sv
// Arbitrates two cores onto one L2 port; state | meaning: IDLE wait+arbitrate, LOOKUP L2 probe,
// FILL dmem read for FILL_LAT cycles, WRITE flush beat, RESP one-cycle ack to the owner.
module l2_access_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned FILL_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  l2_access_arbiter_if.slave bus
);
  logic [2:0]  state_q, state_d;
  req_t        txn_q, txn_d, cand;
  logic        grant_q, grant_d, rr_q, rr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arb_valid, arb_id;
  logic        ack0_q, ack1_q, flush_q, flush_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [31:0] addr_q, bdata_q, bdata_d;
  logic [23:0] tag_q;

  rr_arbiter2 u_rr (
    .req         ({bus.req1, bus.req0}),
    .rr          (rr_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    cand.op    = arb_id ? bus.op1    : bus.op0;
    cand.addr  = arb_id ? bus.addr1  : bus.addr0;
    cand.wdata = arb_id ? bus.wdata1 : bus.wdata0;
    case (state_q)
      ST_IDLE: if (arb_valid) begin
        txn_d   = cand;
        grant_d = arb_id;
        rr_d    = ~arb_id;
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (txn_q.op == OP_LOAD) begin
          if (bus.l2_hit == L2_HIT_CODE) begin
            rdata_d = bus.l2_data;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(FILL_LAT);
            state_d = ST_FILL;
          end
        end else if (txn_q.op == OP_FLUSH) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_FILL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = bus.dmem_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // L2-side outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    opcode_d = '0;
    flush_d  = 1'b0;
    bdata_d  = '0;
    case (state_d)
      ST_LOOKUP: if (txn_d.op == OP_LOAD) opcode_d = L2_OPC_LOAD;
      ST_FILL:   opcode_d = L2_OPC_LOAD;
      ST_WRITE: begin
        opcode_d = L2_OPC_STORE;
        flush_d  = 1'b1;
        bdata_d  = txn_d.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      txn_q    <= '0;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      opcode_q <= '0;
      flush_q  <= 1'b0;
      addr_q   <= '0;
      bdata_q  <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ack0_q   <= (state_d == ST_RESP) && !grant_d;
      ack1_q   <= (state_d == ST_RESP) && grant_d;
      opcode_q <= opcode_d;
      flush_q  <= flush_d;
      addr_q   <= (state_d != ST_IDLE) ? txn_d.addr : '0;
      bdata_q  <= bdata_d;
      tag_q    <= (state_d != ST_IDLE) ? {txn_d.addr[31:9], 1'b0} : '0;
    end
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata          = rdata_q;
  assign bus.l2_opcode      = opcode_q;
  assign bus.l2_flush       = flush_q;
  assign bus.l2_bus_address = addr_q;
  assign bus.l2_bus_data    = bdata_q;
  assign bus.l2_bus_tag     = tag_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.grant_id       = grant_q;
endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed plus randomized bench; a transaction-level model predicts owner, latency and data per request.
module tb_l2_access_arbiter;
  localparam int FL = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  l2_access_arbiter_if bus ();

  l2_access_arbiter #(.FILL_LAT(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          rr_m = 1'b0;
  logic [31:0] rdata_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit c, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    if (c) begin
      bus.req1 = 1'b1; bus.op1 = op; bus.addr1 = a; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.op0 = op; bus.addr0 = a; bus.wdata0 = wd;
    end
  endtask

  // A core that gives up mid-transaction: request dropped, fields scribbled.
  task automatic scramble(input bit c);
    if (c) begin
      bus.req1 = 1'b0; bus.op1 = 2'($urandom()); bus.addr1 = $urandom(); bus.wdata1 = $urandom();
    end else begin
      bus.req0 = 1'b0; bus.op0 = 2'($urandom()); bus.addr0 = $urandom(); bus.wdata0 = $urandom();
    end
  endtask

  function automatic logic [1:0] rand_op();
    int k;
    k = int'($urandom_range(0, 7));
    if (k < 4) return 2'b01;
    if (k < 6) return 2'b10;
    return (k == 6) ? 2'b00 : 2'b11;
  endfunction

  task automatic mid_cycle(input string tag, input bit w, input logic [31:0] a,
                           input logic [6:0] opc, input bit fl);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".gid"}, 32'(bus.grant_id), 32'(w));
    chk({tag, ".ack"}, 32'({bus.ack1, bus.ack0}), 32'd0);
    chk({tag, ".addr"}, bus.l2_bus_address, a);
    chk({tag, ".tag"}, 32'(bus.l2_bus_tag), (a >> 9) << 1);
    chk({tag, ".opc"}, 32'(bus.l2_opcode), 32'(opc));
    chk({tag, ".flush"}, 32'(bus.l2_flush), 32'(fl));
    chk({tag, ".rdata"}, bus.rdata, rdata_m);
  endtask

  // Entered at a negedge with the DUT idle and at least one request up; returns at the next idle negedge.
  task automatic run_one(input bit hit, input bit mutate, input logic [31:0] ldata,
                         input logic [31:0] ddata, input string tag);
    bit          w;
    logic [1:0]  op, mc;
    logic [31:0] a, wd;
    w    = (bus.req0 && bus.req1) ? rr_m : bus.req1;
    rr_m = ~w;
    op   = w ? bus.op1 : bus.op0;
    a    = w ? bus.addr1 : bus.addr0;
    wd   = w ? bus.wdata1 : bus.wdata0;
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    tick();
    mc = 2'($urandom_range(0, 2));
    if (mc == 2'd2) mc = 2'b11;
    bus.l2_hit  = hit ? 2'b10 : mc;
    bus.l2_data = ldata;
    mid_cycle({tag, ".lookup"}, w, a, (op == 2'b01) ? 7'h03 : 7'h00, 1'b0);
    if (mutate) scramble(w);
    if (op == 2'b01 && hit) rdata_m = ldata;
    tick();
    bus.l2_hit = 2'b00;
    if (op == 2'b01 && !hit) begin
      for (int i = 0; i < FL; i++) begin
        bus.dmem_data = (i == FL - 1) ? ddata : $urandom();
        mid_cycle({tag, ".fill"}, w, a, 7'h03, 1'b0);
        if (mutate) scramble(w);
        tick();
      end
      rdata_m = ddata;
    end else if (op == 2'b10) begin
      mid_cycle({tag, ".write"}, w, a, 7'h23, 1'b1);
      chk({tag, ".wdata"}, bus.l2_bus_data, wd);
      tick();
    end
    chk({tag, ".resp_ack"}, 32'({bus.ack1, bus.ack0}), w ? 32'd2 : 32'd1);
    chk({tag, ".resp_rdata"}, bus.rdata, rdata_m);
    chk({tag, ".resp_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".resp_gid"}, 32'(bus.grant_id), 32'(w));
    chk({tag, ".resp_opc"}, 32'(bus.l2_opcode), 32'd0);
    chk({tag, ".resp_flush"}, 32'(bus.l2_flush), 32'd0);
    chk({tag, ".resp_addr"}, bus.l2_bus_address, a);
    if (w) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    tick();
    chk({tag, ".post_ack"}, 32'({bus.ack1, bus.ack0}), 32'd0);
    chk({tag, ".post_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".post_opc"}, 32'(bus.l2_opcode), 32'd0);
    chk({tag, ".post_flush"}, 32'(bus.l2_flush), 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    tick();
    tick();
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".rdata"}, bus.rdata, 32'd0);
    chk({tag, ".gid"}, 32'(bus.grant_id), 32'd0);
    reset   = 1'b1;
    rr_m    = 1'b0;
    rdata_m = '0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = '0; bus.op1 = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.l2_hit = '0; bus.l2_data = '0; bus.dmem_data = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.gid", 32'(bus.grant_id), 32'd0);
    chk("rst.ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.opc", 32'(bus.l2_opcode), 32'd0);
    chk("rst.flush", 32'(bus.l2_flush), 32'd0);
    chk("rst.addr", bus.l2_bus_address, 32'd0);
    chk("rst.data", bus.l2_bus_data, 32'd0);
    chk("rst.tag", 32'(bus.l2_bus_tag), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    drive(1'b0, 2'b01, 32'h0000_1204, 32'h0);
    run_one(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, "hit0");
    chk("hit0.rdata_hold", bus.rdata, 32'hDEAD_BEEF);

    drive(1'b1, 2'b01, 32'h0000_8000, 32'h0);
    run_one(1'b0, 1'b0, 32'h0, 32'h1234_5678, "miss1");

    reset_pulse("rst_a");
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 2'b01, 32'h0000_0100, 32'h0);
      drive(1'b1, 2'b01, 32'h0000_0200, 32'h0);
      run_one(1'b1, 1'b0, $urandom(), 32'h0, "rr_first");
      run_one(1'b1, 1'b0, $urandom(), 32'h0, "rr_second");
    end

    drive(1'b0, 2'b10, 32'h0000_0400, 32'hA5A5_A5A5);
    run_one(1'b0, 1'b0, $urandom(), $urandom(), "flush0");

    reset_pulse("rst_b");
    drive(1'b0, 2'b10, 32'h0000_0600, 32'h1111_2222);
    drive(1'b1, 2'b01, 32'h0000_0700, 32'h0);
    run_one(1'b0, 1'b0, $urandom(), 32'h7777_8888, "rstrr_first");
    run_one(1'b1, 1'b0, 32'h5555_6666, 32'h0, "rstrr_second");

    drive(1'b1, 2'b01, 32'h0000_3000, 32'h0);
    tick();
    bus.l2_hit = 2'b01;
    tick();
    chk("rstfill.opc_before", 32'(bus.l2_opcode), 32'h03);
    #2 reset = 1'b0;
    #1;
    chk("rstfill.busy", 32'(bus.busy), 32'd0);
    chk("rstfill.opc", 32'(bus.l2_opcode), 32'd0);
    chk("rstfill.addr", bus.l2_bus_address, 32'd0);
    chk("rstfill.tag", 32'(bus.l2_bus_tag), 32'd0);
    chk("rstfill.rdata", bus.rdata, 32'd0);
    chk("rstfill.gid", 32'(bus.grant_id), 32'd0);
    chk("rstfill.ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    @(negedge clk);
    chk("rstfill.ack_held", 32'({bus.ack1, bus.ack0}), 32'd0);
    reset   = 1'b1;
    rr_m    = 1'b0;
    rdata_m = '0;
    run_one(1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, "rstfill_after");

    drive(1'b0, 2'b01, 32'h0000_5000, 32'h0);
    run_one(1'b0, 1'b1, $urandom(), 32'h0BAD_F00D, "drop0");

    for (int n = 0; n < 300; n++) begin
      if (!bus.req0 && $urandom_range(0, 1) == 1) drive(1'b0, rand_op(), $urandom(), $urandom());
      if (!bus.req1 && $urandom_range(0, 1) == 1) drive(1'b1, rand_op(), $urandom(), $urandom());
      if (!bus.req0 && !bus.req1) begin
        tick();
        chk("rnd.idle_busy", 32'(bus.busy), 32'd0);
      end else begin
        run_one(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom(), $urandom(), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
